// File: rtl/fc_seq_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
package fc_seq_pkg;

  typedef enum logic [1:0] {LOAD, SETTLE, CAPTURE, DRAIN} state_t;

  // Index width with a 1-bit floor so single-entry arrays still get a pointer.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// Activation input stream and neuron result output stream of fc_layer_seq.
interface fc_layer_seq_if
  import fc_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OW    = 22,
  parameter int IW    = idx_w(10)
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic [IW-1:0]        out_idx;
  logic                 out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/fc_argmax.sv
// Running signed maximum over result beats; ties keep the lower index.
module fc_argmax
  import fc_seq_pkg::*;
#(
  parameter int OW = 22,
  parameter int NW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fire,
  input  logic                 first,
  input  logic                 last,
  input  logic signed [OW-1:0] data,
  input  logic [NW-1:0]        idx,
  output logic                 cls_valid,
  output logic [NW-1:0]        cls_idx
);

  logic signed [OW-1:0] max_q;
  logic [NW-1:0]        max_idx_q;
  logic                 take;

  // Strict greater-than so an equal later value never displaces the earlier one.
  assign take      = first || (data > max_q);
  assign cls_valid = fire && last;
  assign cls_idx   = take ? idx : max_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_idx_q <= '0;
    end else if (fire && take) begin
      max_idx_q <= idx;
    end
  end

  always_ff @(posedge clk) begin
    if (fire && take) begin
      max_q <= data;
    end
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Frame sequencer for one constant-coefficient FC layer: buffer, settle, capture, drain.
// Optional FC_ARGMAX_EN adds a per-frame argmax classification output.
module fc_layer_seq
  import fc_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int NEUR   = 10,
  parameter int OW     = 22,
  parameter int SETTLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fc_layer_seq_if.slave          io,
  output logic [IN*WIDTH-1:0]    x_bus,
  input  logic [NEUR*OW-1:0]     z_bus,
  output logic                   err_short
`ifdef FC_ARGMAX_EN
  ,
  output logic                   cls_valid,
  output logic [idx_w(NEUR)-1:0] cls_idx
`endif
);

  localparam int PW = idx_w(IN);
  localparam int NW = idx_w(NEUR);
  localparam int SC = (SETTLE > 0) ? SETTLE : 1;
  localparam int CW = idx_w(SC);

  state_t               state;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        settle_cnt;
  logic [WIDTH-1:0]     xbuf [IN];
  logic signed [OW-1:0] res [NEUR];
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_last;
  logic [NW-1:0]        out_idx;
  logic                 accept;
  logic                 at_end;

  assign accept = in_ready && io.in_valid;
  assign at_end = (wr_ptr == PW'(IN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= fc_seq_pkg::LOAD;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      err_short  <= 1'b0;
      wr_ptr     <= '0;
      settle_cnt <= '0;
      for (int k = 0; k < IN; k++) xbuf[k] <= '0;
    end else begin
      case (state)
        // LOAD: fill the buffer; a short frame zero-pads the untouched tail.
        fc_seq_pkg::LOAD: begin
          if (accept) begin
            xbuf[wr_ptr] <= io.in_data;
            wr_ptr       <= wr_ptr + 1'b1;
            if (io.in_last && !at_end) begin
              for (int k = 0; k < IN; k++) begin
                if (k > int'(wr_ptr)) xbuf[k] <= '0;
              end
              err_short <= 1'b1;
            end
            if (io.in_last || at_end) begin
              state      <= fc_seq_pkg::SETTLE;
              in_ready   <= 1'b0;
              settle_cnt <= '0;
            end
          end
        end
        // SETTLE: bus frozen while the combinational neuron trees resolve.
        fc_seq_pkg::SETTLE: begin
          if (settle_cnt == CW'(SC - 1)) state <= fc_seq_pkg::CAPTURE;
          else                           settle_cnt <= settle_cnt + 1'b1;
        end
        fc_seq_pkg::CAPTURE: begin
          state     <= fc_seq_pkg::DRAIN;
          out_valid <= 1'b1;
          out_idx   <= '0;
          out_last  <= (NEUR == 1);
        end
        // DRAIN: one result per accepted beat, then reopen the input.
        fc_seq_pkg::DRAIN: begin
          if (io.out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_idx   <= '0;
              out_last  <= 1'b0;
              wr_ptr    <= '0;
              in_ready  <= 1'b1;
              state     <= fc_seq_pkg::LOAD;
            end else begin
              out_idx  <= out_idx + 1'b1;
              out_last <= (NW'(out_idx + 1'b1) == NW'(NEUR - 1));
            end
          end
        end
        default: state <= fc_seq_pkg::LOAD;
      endcase
    end
  end

  // Results are pure data: captured once per frame, no reset needed.
  always_ff @(posedge clk) begin
    if (state == fc_seq_pkg::CAPTURE) begin
      for (int j = 0; j < NEUR; j++) res[j] <= $signed(z_bus[j*OW +: OW]);
    end
  end

  for (genvar g = 0; g < IN; g++) begin : g_xbus
    assign x_bus[g*WIDTH +: WIDTH] = xbuf[g];
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.out_idx   = out_idx;
  assign io.out_last  = out_last;
  assign io.out_data  = res[out_idx];

`ifdef FC_ARGMAX_EN
  logic out_fire;
  assign out_fire = out_valid && io.out_ready;

  fc_argmax #(.OW(OW), .NW(NW)) u_argmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .fire      (out_fire),
    .first     (out_idx == '0),
    .last      (out_last),
    .data      (res[out_idx]),
    .idx       (out_idx),
    .cls_valid (cls_valid),
    .cls_idx   (cls_idx)
  );
`endif

endmodule
